// File: rtl/flicker_sequencer_pkg.sv
// Shared types and constants for the flicker sequencer and its PWM stage.
// The optional stepped ramp is selected with the FLICKER_RAMP_EN macro in flicker_sequencer.sv.
package flicker_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAW_T,
        DRAW_H,
        RAMP,
        HOLD
    } state_t;

    localparam int DRAW_CYCLES       = 4;
    localparam int PWM_W             = 4;
    localparam int LEVEL_MIN_DEFAULT = 4;

    function automatic logic [PWM_W-1:0] floor_level(input logic [PWM_W-1:0] value,
                                                     input logic [PWM_W-1:0] floor_value);
        return (value < floor_value) ? floor_value : value;
    endfunction

endpackage

// File: rtl/flicker_sequencer_pwm.sv
// Free-running 16-step PWM: pwm_out is high while the phase counter is below level.
module flicker_pwm
    import flicker_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [PWM_W-1:0] level,
    output logic             pwm_out
);

    logic [PWM_W-1:0] phase;

    // NOTE: registers are written with <= so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase   <= '0;
            pwm_out <= 1'b0;
        end else begin
            phase   <= phase + 1'b1;
            pwm_out <= (phase < level);
        end
    end

endmodule

// File: rtl/flicker_sequencer.sv
// Candle-flicker sequencer: draws a random brightness target and hold time, then ramps and holds.
// Define FLICKER_RAMP_EN for a tick-paced ramp; otherwise level jumps straight to the target.
module flicker_sequencer
    import flicker_sequencer_pkg::*;
#(
    parameter int DIV_W     = 8,
    parameter int LEVEL_MIN = LEVEL_MIN_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [3:0]       rng_value,
    output logic             rng_enable,
    output logic [PWM_W-1:0] level,
    output logic             pwm_out,
    output logic             busy
);

    localparam int               CNT_W       = $clog2(DRAW_CYCLES);
    localparam logic [CNT_W-1:0] DRAW_LAST   = CNT_W'(DRAW_CYCLES - 1);
    localparam logic [PWM_W-1:0] LEVEL_FLOOR = PWM_W'(LEVEL_MIN);

    state_t           state, state_d;
    logic [CNT_W-1:0] draw_cnt, draw_cnt_d;
    logic [PWM_W-1:0] level_d, target, target_d;
    logic [4:0]       hold, hold_d;
    logic [DIV_W-1:0] presc;
    logic             tick;
    logic             rng_enable_d;

    assign tick = run && (presc == '1);
    assign busy = (state != IDLE);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state;
        draw_cnt_d = draw_cnt;
        level_d    = level;
        target_d   = target;
        hold_d     = hold;
        if (!run) begin
            state_d    = IDLE;
            draw_cnt_d = '0;
            level_d    = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_d    = DRAW_T;
                    draw_cnt_d = '0;
                end
                DRAW_T: begin
                    draw_cnt_d = draw_cnt + 1'b1;
                    if (draw_cnt == DRAW_LAST) begin
                        state_d    = DRAW_H;
                        draw_cnt_d = '0;
                        target_d   = floor_level(rng_value, LEVEL_FLOOR);
                    end
                end
                DRAW_H: begin
                    draw_cnt_d = draw_cnt + 1'b1;
                    if (draw_cnt == DRAW_LAST) begin
                        state_d    = RAMP;
                        draw_cnt_d = '0;
                        hold_d     = {1'b0, rng_value} + 5'd1;
                    end
                end
                RAMP: begin
`ifdef FLICKER_RAMP_EN
                    if (level == target) begin
                        state_d = HOLD;
                    end else if (tick) begin
                        level_d = (level < target) ? level + 1'b1 : level - 1'b1;
                    end
`else
                    level_d = target;
                    state_d = HOLD;
`endif
                end
                HOLD: begin
                    if (tick) begin
                        hold_d = hold - 5'd1;
                        if (hold <= 5'd1) state_d = DRAW_T;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        rng_enable_d = (state_d == DRAW_T) || (state_d == DRAW_H);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            draw_cnt   <= '0;
            level      <= '0;
            target     <= '0;
            hold       <= '0;
            presc      <= '0;
            rng_enable <= 1'b0;
        end else begin
            state      <= state_d;
            draw_cnt   <= draw_cnt_d;
            level      <= level_d;
            target     <= target_d;
            hold       <= hold_d;
            presc      <= run ? presc + 1'b1 : '0;
            rng_enable <= rng_enable_d;
        end
    end

    // The PWM compares against the upcoming level so pwm_out and level change on the same edge.
    flicker_pwm u_pwm (
        .clk     (clk),
        .reset   (reset),
        .level   (level_d),
        .pwm_out (pwm_out)
    );

endmodule

// File: tb/tb_flicker_sequencer.sv
// Self-checking bench for flicker_sequencer (DIV_W=2): directed draws plus randomized run/reset/rng traffic.
// Works in both builds; FLICKER_RAMP_EN selects the stepped-ramp behaviour in the reference model.
module tb_flicker_sequencer;

    localparam int LMIN = 4;
`ifdef FLICKER_RAMP_EN
    localparam bit RAMP_EN = 1'b1;
`else
    localparam bit RAMP_EN = 1'b0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_DRAW = 1;
    localparam int M_RAMP = 2;
    localparam int M_HOLD = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [3:0] rng_value;
    logic       rng_enable;
    logic [3:0] level;
    logic       pwm_out;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one draw phase of 8 cycles, then ramp/hold timed in prescaler ticks.
    int m_mode      = M_IDLE;
    int m_draw_age  = 0;
    int m_cycles    = 0;
    int m_level     = 0;
    int m_target    = 0;
    int m_hold      = 0;
    int m_pwm_phase = 0;
    bit m_pwm       = 1'b0;

    flicker_sequencer #(.DIV_W(2), .LEVEL_MIN(LMIN)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .rng_value  (rng_value),
        .rng_enable (rng_enable),
        .level      (level),
        .pwm_out    (pwm_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_edge();
        bit tick;
        if (reset) begin
            m_mode = M_IDLE; m_draw_age = 0; m_cycles = 0; m_level = 0;
            m_target = 0; m_hold = 0; m_pwm_phase = 0; m_pwm = 1'b0;
            return;
        end
        if (!run) begin
            m_mode = M_IDLE; m_cycles = 0; m_level = 0;
        end else begin
            tick = (m_cycles % 4) == 3;
            m_cycles++;
            if (m_mode == M_IDLE) begin
                m_mode = M_DRAW; m_draw_age = 0;
            end else if (m_mode == M_DRAW) begin
                if (m_draw_age == 3) m_target = (int'(rng_value) < LMIN) ? LMIN : int'(rng_value);
                if (m_draw_age == 7) begin
                    m_hold = int'(rng_value) + 1;
                    m_mode = M_RAMP;
                end
                m_draw_age++;
            end else if (m_mode == M_RAMP) begin
                if (!RAMP_EN) begin
                    m_level = m_target; m_mode = M_HOLD;
                end else if (m_level == m_target) begin
                    m_mode = M_HOLD;
                end else if (tick) begin
                    m_level += (m_target > m_level) ? 1 : -1;
                end
            end else if (tick) begin
                m_hold--;
                if (m_hold == 0) begin
                    m_mode = M_DRAW; m_draw_age = 0;
                end
            end
        end
        m_pwm = m_pwm_phase < m_level;
        m_pwm_phase = (m_pwm_phase + 1) % 16;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("level", level, m_level);
        check("pwm_out", pwm_out, m_pwm);
        check("rng_enable", rng_enable, m_mode == M_DRAW);
        check("busy", busy, m_mode != M_IDLE);
    endtask

    // Run one full draw: rng_value=t through the target half, h through the hold half.
    task automatic draw(input logic [3:0] t, input logic [3:0] h);
        int en_cycles = 0;
        bit reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            rng_value = (m_mode == M_DRAW && m_draw_age >= 4) ? h : t;
            step();
            if (rng_enable === 1'b1) en_cycles++;
            reached = (m_mode == M_RAMP);
        end
        check("draw_reached_ramp", reached, 1);
        check("draw_enable_cycles", en_cycles, 8);
    endtask

    task automatic wait_mode(input int mode, input int limit);
        bit reached = (m_mode == mode);
        for (int i = 0; i < limit && !reached; i++) begin
            step();
            reached = (m_mode == mode);
        end
        check("wait_mode", reached, 1);
    endtask

    task automatic duty(input string tag, input int expected_high);
        int highs = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (pwm_out === 1'b1) highs++;
        end
        check(tag, highs, expected_high);
    endtask

    initial begin
        bit hit;
        reset = 1'b1; run = 1'b1; rng_value = 4'd0;
        repeat (3) step();
        reset = 1'b0;

        // First edge after reset goes IDLE->DRAW_T; target 9, hold 3 ticks.
        draw(4'd9, 4'd2);
        if (!RAMP_EN) begin
            step();
            check("jump_level", level, 9);
        end
        wait_mode(M_HOLD, 100);
        check("target_9", level, 9);

        draw(4'd1, 4'd5);
        wait_mode(M_HOLD, 100);
        check("target_floor", level, 4);

        draw(4'd8, 4'd15);
        wait_mode(M_HOLD, 100);
        duty("duty_8", 8);

        draw(4'd15, 4'd15);
        wait_mode(M_HOLD, 100);
        duty("duty_15", 15);

        run = 1'b0;
        duty("duty_0", 0);

        // Drop run mid-ramp (at level 5 when stepping), then restart.
        run = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            rng_value = (m_mode == M_DRAW && m_draw_age >= 4) ? 4'd0 : 4'd12;
            step();
            hit = (m_mode == M_RAMP) && (m_level == 5 || !RAMP_EN);
        end
        check("reach_mid_ramp", hit, 1);
        run = 1'b0;
        step();
        check("drop_busy", busy, 0);
        check("drop_level", level, 0);
        check("drop_rng_enable", rng_enable, 0);
        run = 1'b1;
        step();
        check("restart_draw", rng_enable, 1);

        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 255) == 0);
            run       = ($urandom_range(0, 63) != 0);
            rng_value = 4'($urandom_range(0, 15));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/flicker_sequencer.md
FLICKER_SEQUENCER -- requirements
Module: flicker_sequencer

Interface
REQ-001 SHALL have parameter DIV_W, default 8: prescaler width; one tick every 2^DIV_W clk cycles.
REQ-002 SHALL have parameter LEVEL_MIN, default 4: floor applied to drawn brightness targets.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port run, input, 1: high enables flicker sequencing; low forces IDLE.
REQ-006 SHALL have port rng_value, input, 4: registered nibble from the external lfsr block.
REQ-007 SHALL have port rng_enable, output, 1: shift enable to the lfsr block; registered.
REQ-008 SHALL have port level, output, 4: current brightness, 0..15; registered.
REQ-009 SHALL have port pwm_out, output, 1: PWM of level, period 16 clk; registered.
REQ-010 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, DRAW_T, DRAW_H, RAMP and HOLD.
REQ-012 IDLE -> DRAW_T on the first clk where run=1.
REQ-013 DRAW_T SHALL last exactly 4 clk with rng_enable=1, giving the lfsr 4 fresh shifts.
REQ-014 DRAW_T -> DRAW_H; on the first DRAW_H cycle, target = max(rng_value, LEVEL_MIN) SHALL be captured.
REQ-015 DRAW_H SHALL last exactly 4 clk with rng_enable=1, so rng_enable is high for 8 consecutive clk per draw.
REQ-016 DRAW_H -> RAMP; on the first RAMP cycle, hold = rng_value + 1 (1..16) SHALL be captured, 5-bit.
REQ-017 rng_enable SHALL be 0 in IDLE, RAMP and HOLD.
REQ-018 Prescaler: free-running DIV_W-bit counter while run=1; tick is asserted when the counter wraps from all-ones to 0; the counter clears on entry to IDLE.
REQ-019 RAMP: on each tick, level moves +/-1 toward target; once level==target (including on entry), -> HOLD on the next clk.
REQ-020 HOLD: decrement hold on each tick; when hold reaches 0 -> DRAW_T.
REQ-021 level SHALL hold its value in DRAW_T, DRAW_H and HOLD.
REQ-022 PWM: 4-bit counter 0..15 wrapping; pwm_out = (counter < level); level 0 -> constant 0; level 15 -> high 15 of 16 clk.
REQ-023 run=0 in any state SHALL force IDLE on the next clk: level=0, pwm_out=0, rng_enable=0.
REQ-024 run=0 coincident with a capture or tick SHALL take priority: no capture, no level step.

Reset
REQ-025 reset SHALL dominate run and SHALL set: state=IDLE, level=0, pwm_out=0, rng_enable=0, busy=0, target=0, hold=0, prescaler=0, PWM counter=0.
REQ-026 reset mid-operation SHALL take effect on the next clk edge with no residual draw or ramp.

Configuration
REQ-027 With macro FLICKER_RAMP_EN defined, RAMP SHALL step level as in REQ-019.
REQ-028 Without FLICKER_RAMP_EN, level SHALL be loaded with target on the first RAMP cycle and the state SHALL go to HOLD on the next clk, independent of tick.

Structure
REQ-029 A shared package SHALL hold the state enum, DRAW_CYCLES=4, PWM_W=4 and the default LEVEL_MIN.
REQ-030 PWM generation SHALL be a sub-module named flicker_pwm, with inputs clk, reset and level, and output pwm_out.
REQ-031 The lfsr block SHALL be instantiated outside this module and connected through rng_enable/rng_value.

Verification (bench drives rng_value directly, DIV_W=2)
REQ-032 Stimulus: reset=1 with run=1 for 3 clk. Required response: level=0, pwm_out=0, rng_enable=0 and busy=0 throughout; DRAW_T is entered 1 clk after reset falls.
REQ-033 Stimulus: run=1, rng_value=9 during DRAW_T, then 2 during DRAW_H. Required response: rng_enable is high for exactly 8 clk; target=9; level ramps 0->9 over 9 ticks (36 clk); HOLD lasts 3 ticks; then rng_enable rises again.
REQ-034 Stimulus: rng_value=1 at target capture. Required response: target=4 and the ramp stops at level 4.
REQ-035 Stimulus: level held at 8. Required response: pwm_out is high exactly 8 of every 16 clk; at level 0 it is always low; at level 15 it is high 15 of 16.
REQ-036 Stimulus: run dropped mid-RAMP at level 5. Required response: next clk shows IDLE, level=0, busy=0 and rng_enable=0; run reasserted restarts at DRAW_T.
REQ-037 Stimulus: build without FLICKER_RAMP_EN and rng_value=12. Required response: level jumps 0->12 one clk after RAMP entry, and HOLD follows on the next clk.
